// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multi-cycle CPU datapath. It steps each
//   instruction through fetch, decode, execute, memory and write-back states.
//   It drives every datapath enable and the 2-bit ALUctr that feeds the
//   ALU-control decoder.
//
//   Moore machine: the outputs are decoded from the registered state.
//   There are three exceptions:
//     - pc_wr in BRANCH follows the live ALU zero flag.
//     - illegal/instr_done in DECODE depend on the live opcode.
//     - With MC_CTRL_STALL_EN defined, the handshake enables are gated by
//       mem_ready.
//
// Optional feature macro: MC_CTRL_STALL_EN
//   Defined   : FETCH, MEM_RD and MEM_WR wait for mem_ready = 1.
//   Undefined : mem_ready is ignored and every state lasts one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   instruction[31:26] from the IR
//   zero       in   ALU zero flag (same cycle)
//   mem_ready  in   memory access complete (stall build only)
//   pc_wr      out  PC load enable (branch condition folded in)
//   ir_wr      out  IR load enable
//   mem_rd     out  memory read strobe
//   mem_wr     out  memory write strobe
//   iord       out  memory address select: 0 = PC, 1 = ALUOut
//   reg_wr     out  register-file write enable
//   reg_dst    out  destination: 0 = rt, 1 = rd
//   mem_to_reg out  write-back data: 0 = ALUOut, 1 = MDR
//   alu_src_a  out  0 = PC, 1 = regA
//   alu_src_b  out  00 regB, 01 const 4, 10 ext imm, 11 ext imm << 2
//   ext_zero   out  1 = zero-extend imm, 0 = sign-extend
//   pc_src     out  00 ALU result, 01 ALUOut, 10 jump target
//   ALUctr     out  00 add, 01 sub, 10 R-type, 11 ori
//   instr_done out  one-cycle pulse in the last state of each instruction
//   illegal    out  one-cycle pulse in DECODE for an undecodable opcode
//   state      out  current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic [1:0] ALUctr,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_WB_I     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t r_state;
  logic   r_is_ori;
  logic   r_armed;   // one quiet INIT cycle after reset release
  logic   w_mem_go;  // memory handshake complete this cycle
  logic   w_legal;

`ifdef MC_CTRL_STALL_EN
  assign w_mem_go = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_go           = 1'b1;
`endif

  assign w_legal = (opcode == OP_R)   || (opcode == OP_LW)   ||
                   (opcode == OP_SW)  || (opcode == OP_BEQ)  ||
                   (opcode == OP_J)   || (opcode == OP_ADDI) ||
                   (opcode == OP_ORI);

  assign state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_INIT;
      r_is_ori <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          // The first edge after reset release only arms the machine.
          // Fetch starts on the second edge.
          r_armed <= 1'b1;
          if (r_armed) r_state <= S_FETCH;
        end
        S_FETCH:  if (w_mem_go) r_state <= S_DECODE;
        S_DECODE: begin
          // Latch the ori flag so EXEC_I does not depend on a changing IR.
          r_is_ori <= (opcode == OP_ORI);
          case (opcode)
            OP_LW, OP_SW:    r_state <= S_MEM_ADDR;
            OP_R:            r_state <= S_EXEC_R;
            OP_BEQ:          r_state <= S_BRANCH;
            OP_J:            r_state <= S_JUMP;
            OP_ADDI, OP_ORI: r_state <= S_EXEC_I;
            default:         r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (w_mem_go) r_state <= S_WB_MEM;
        S_WB_MEM:   r_state <= S_FETCH;
        S_MEM_WR:   if (w_mem_go) r_state <= S_FETCH;
        S_EXEC_R:   r_state <= S_WB_R;
        S_WB_R:     r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        S_EXEC_I:   r_state <= S_WB_I;
        S_WB_I:     r_state <= S_FETCH;
        default:    r_state <= S_INIT;  // codes 13-15 recover through INIT
      endcase
    end
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    pc_src     = 2'b00;
    ALUctr     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // The read strobe stays asserted while waiting.
        // The loads fire only on completion.
        mem_rd    = 1'b1;
        ir_wr     = w_mem_go;
        pc_wr     = w_mem_go;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;  // branch target into ALUOut
        illegal    = !w_legal;
        instr_done = !w_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr     = 1'b1;
        iord       = 1'b1;
        instr_done = w_mem_go;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUctr    = 2'b10;
      end
      S_WB_R: begin
        reg_wr     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        ALUctr     = 2'b01;
        pc_src     = 2'b01;
        pc_wr      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_wr      = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUctr    = r_is_ori ? 2'b11 : 2'b00;
        ext_zero  = r_is_ori;
      end
      S_WB_I: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
